// File: rtl/video_timing_gen_if.sv
// Bundle between the video timing generator and its pixel source / TMDS sink.
// master: the timing generator. slave: the side that supplies pixels and
// consumes the timed video stream.
interface video_timing_gen_if;
  logic [1:0]  i_pattern;
  logic [23:0] i_bgr;
  logic        o_req;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic        o_hs;
  logic        o_vs;
  logic        o_de;
  logic [23:0] o_bgr;
  logic        o_frame_start;

  modport master (
    input  i_pattern, i_bgr,
    output o_req, o_x, o_y, o_hs, o_vs, o_de, o_bgr, o_frame_start
  );

  modport slave (
    output i_pattern, i_bgr,
    input  o_req, o_x, o_y, o_hs, o_vs, o_de, o_bgr, o_frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Video timing generator: h/v counters (stage 0), pixel request and
// coordinates (stage 1), registered sync/DE/pixel outputs (stage 2).
// Optional internal test-pattern generator enabled by defining
// VIDEO_TIMING_GEN_PATTERN_EN; without it o_bgr is the external i_bgr.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  video_timing_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS    = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS    = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE    = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);

  // ---- stage 0: raster counters and region decode
  logic [11:0] h_p0, v_p0;
  logic        active_p0, hs_p0, vs_p0, fs_p0;

  // Free-running raster position; v advances when h wraps
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_p0 <= '0;
      v_p0 <= '0;
    end else if (h_p0 == H_LAST) begin
      h_p0 <= '0;
      v_p0 <= (v_p0 == V_LAST) ? 12'd0 : v_p0 + 12'd1;
    end else begin
      h_p0 <= h_p0 + 12'd1;
    end
  end

  // Region flags for the current raster position
  always_comb begin
    active_p0 = (h_p0 < H_ACT) && (v_p0 < V_ACT);
    hs_p0     = (h_p0 >= H_SS) && (h_p0 < H_SE);
    vs_p0     = (v_p0 >= V_SS) && (v_p0 < V_SE);
    fs_p0     = (h_p0 == 12'd0) && (v_p0 == 12'd0);
  end

  // ---- stage 1: pixel request, coordinates, delayed flags
  logic        req_p1, hs_p1, vs_p1, fs_p1;
  logic [11:0] x_p1, y_p1;
  logic [23:0] pix_p1;

  // Request/coordinates for the external source; coordinates park at 0
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_p1 <= 1'b0;
      x_p1   <= '0;
      y_p1   <= '0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      fs_p1  <= 1'b0;
    end else begin
      req_p1 <= active_p0;
      x_p1   <= active_p0 ? h_p0 : 12'd0;
      y_p1   <= active_p0 ? v_p0 : 12'd0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      fs_p1  <= fs_p0 && active_p0;
    end
  end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

  logic [1:0]  pat_sel;
  logic [11:0] bar_px;
  logic [2:0]  bar_idx;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'h00FFFF;
      3'd2:    bar_color = 24'hFFFF00;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'h0000FF;
      3'd6:    bar_color = 24'hFF0000;
      default: bar_color = 24'h000000;
    endcase
  endfunction

  // Pattern select is frozen for a whole frame, taken at raster origin
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      pat_sel <= 2'd0;
    else if (fs_p0) pat_sel <= vif.i_pattern;
  end

  // Bar position tracks the stage-1 column; restarts every line
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (h_p0 == 12'd0) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == BAR_LAST) begin
      bar_px  <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_px  <= bar_px + 12'd1;
    end
  end

  // Pattern pixel for the stage-1 coordinate
  always_comb begin
    pix_p1 = 24'h000000;
    case (pat_sel)
      2'd0:    pix_p1 = bar_color(bar_idx);
      2'd1:    pix_p1 = (x_p1[3] ^ y_p1[3]) ? 24'hFFFFFF : 24'h000000;
      2'd2:    pix_p1 = {3{x_p1[7:0]}};
      default: pix_p1 = vif.i_bgr;
    endcase
  end
`else
  logic unused_pattern;
  assign unused_pattern = ^vif.i_pattern;

  // External pixel arrives during the request cycle
  always_comb begin
    pix_p1 = vif.i_bgr;
  end
`endif

  // ---- stage 2: registered video outputs
  logic        hs_p2, vs_p2, de_p2, fs_p2;
  logic [23:0] bgr_p2;

  // Apply sync polarity and blank pixel data outside the active area
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hs_p2  <= ~HS_POL;
      vs_p2  <= ~VS_POL;
      de_p2  <= 1'b0;
      fs_p2  <= 1'b0;
      bgr_p2 <= '0;
    end else begin
      hs_p2  <= hs_p1 ? HS_POL : ~HS_POL;
      vs_p2  <= vs_p1 ? VS_POL : ~VS_POL;
      de_p2  <= req_p1;
      fs_p2  <= fs_p1;
      bgr_p2 <= req_p1 ? pix_p1 : 24'h000000;
    end
  end

  assign vif.o_req         = req_p1;
  assign vif.o_x           = x_p1;
  assign vif.o_y           = y_p1;
  assign vif.o_hs          = hs_p2;
  assign vif.o_vs          = vs_p2;
  assign vif.o_de          = de_p2;
  assign vif.o_bgr         = bgr_p2;
  assign vif.o_frame_start = fs_p2;

endmodule
